// File: rtl/axil_apb_pkg.sv
// axil_apb_pkg: FSM state encoding and AXI response codes shared by the AXI4-Lite to APB bridge
package axil_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axil_apb_addr_decode.sv
// axil_apb_addr_decode: combinational region decode, lowest matching slave index wins
//   addr      in   address to decode
//   base/mask in   packed per-slave region base and mask, slave 0 in the LSBs
//   sel       out  one-hot slave select (all zero on a miss)
//   hit       out  some slave matched
module axil_apb_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [NUM_SLAVES*ADDR_W-1:0] base,
  input  logic [NUM_SLAVES*ADDR_W-1:0] mask,
  output logic [NUM_SLAVES-1:0]        sel,
  output logic                         hit
);
  // Scan from the top so a lower-index match overwrites a higher one
  always_comb begin
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((addr & mask[i*ADDR_W +: ADDR_W]) == base[i*ADDR_W +: ADDR_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
  end
  assign hit = |sel;
endmodule

// File: rtl/axil_apb_bridge.sv
// axil_apb_bridge: AXI4-Lite slave to APB4 master bridge, one transaction at a time
//   s_axi_*  AXI4-Lite slave (AW/W/B/AR/R channels), clocked by s_axi_clk, async active-low s_axi_aresetn
//   m_apb_*  APB4 master: shared request, one-hot psel, per-slave pready/pslverr/prdata
//   Unmapped addresses get DECERR without an APB cycle; a stalled slave gets SLVERR after TIMEOUT ACCESS cycles.
module axil_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFFF000}},
  parameter int TIMEOUT    = 16
) (
  input  logic                         s_axi_clk,
  input  logic                         s_axi_aresetn,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [ADDR_W-1:0]            m_apb_paddr,
  output logic [2:0]                   m_apb_pprot,
  output logic                         m_apb_pwrite,
  output logic [DATA_W-1:0]            m_apb_pwdata,
  output logic [DATA_W/8-1:0]          m_apb_pstrb,
  output logic [NUM_SLAVES-1:0]        m_apb_psel,
  output logic                         m_apb_penable,
  input  logic [NUM_SLAVES-1:0]        m_apb_pready,
  input  logic [NUM_SLAVES-1:0]        m_apb_pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] m_apb_prdata
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t                state;
  logic                  last_wr;
  logic [CW-1:0]         cnt;
  logic [1:0]            resp;
  logic [ADDR_W-1:0]     addr_in;
  logic [NUM_SLAVES-1:0] sel;
  logic                  hit;
  logic                  wr_ok;
  logic                  pick_wr;
  logic                  rdy;
  logic                  err;
  logic [DATA_W-1:0]     prd;
  // Address being granted: ready is registered, so it also tells which channel is in handshake
  assign addr_in = s_axi_awready ? s_axi_awaddr : s_axi_araddr;
  assign wr_ok   = s_axi_awvalid && s_axi_wvalid;
  // Reads win unless a read is absent or the previous grant went to a read
  assign pick_wr = wr_ok && (!s_axi_arvalid || !last_wr);
  // psel is zero outside SETUP/ACCESS, so masking with it ignores unselected slaves
  assign rdy     = |(m_apb_pready & m_apb_psel);
  assign err     = |(m_apb_pslverr & m_apb_psel);
  assign s_axi_bresp = resp;
  assign s_axi_rresp = resp;
  always_comb begin
    prd = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      prd = prd | (m_apb_psel[i] ? m_apb_prdata[i*DATA_W +: DATA_W] : '0);
  end
  axil_apb_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W)) u_decode (
    .addr(addr_in),
    .base(SLV_BASE),
    .mask(SLV_MASK),
    .sel (sel),
    .hit (hit)
  );
  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      last_wr       <= 1'b1;
      cnt           <= '0;
      resp          <= RESP_OKAY;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      m_apb_paddr   <= '0;
      m_apb_pprot   <= '0;
      m_apb_pwrite  <= 1'b0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
      m_apb_psel    <= '0;
      m_apb_penable <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (s_axi_awready || s_axi_arready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            m_apb_paddr   <= addr_in;
            m_apb_pwrite  <= s_axi_awready;
            m_apb_pprot   <= s_axi_awready ? s_axi_awprot : s_axi_arprot;
            m_apb_pstrb   <= s_axi_awready ? s_axi_wstrb : '0;
            if (s_axi_awready) m_apb_pwdata <= s_axi_wdata;
            if (hit) begin
              m_apb_psel <= sel;
              state      <= SETUP;
            end else begin
              resp         <= RESP_DECERR;
              s_axi_rdata  <= '0;
              s_axi_bvalid <= s_axi_awready;
              s_axi_rvalid <= !s_axi_awready;
              state        <= RESP;
            end
          end else if (wr_ok || s_axi_arvalid) begin
            s_axi_awready <= pick_wr;
            s_axi_wready  <= pick_wr;
            s_axi_arready <= !pick_wr;
            last_wr       <= pick_wr;
          end
        SETUP: begin
          m_apb_penable <= 1'b1;
          cnt           <= CW'(TIMEOUT);
          state         <= ACCESS;
        end
        ACCESS:
          if (rdy || (TIMEOUT > 0 && cnt == CW'(1))) begin
            // pready is checked first so a completion on the expiring cycle still counts
            resp          <= rdy ? (err ? RESP_SLVERR : RESP_OKAY) : RESP_SLVERR;
            s_axi_rdata   <= (rdy && !m_apb_pwrite) ? prd : '0;
            s_axi_bvalid  <= m_apb_pwrite;
            s_axi_rvalid  <= !m_apb_pwrite;
            m_apb_psel    <= '0;
            m_apb_penable <= 1'b0;
            state         <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        default:
          if ((s_axi_bvalid && s_axi_bready) || (s_axi_rvalid && s_axi_rready)) begin
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
      endcase
    end
  end
endmodule
